// File: rtl/gam_node_updater.sv
// gam_node_updater: read-modify-write of one GAM node per command.
// Reads W and M, adds (X - W) >>> floor(log2(M+1)) to each element, one element per
// cycle, then writes back X, the class name, W and the new hit count M.
// Optional: define GAM_TH_DECAY_EN to also read and decay the node threshold Th.
module gam_node_updater #(
  parameter int unsigned VEC_LEN  = 4,
  parameter int unsigned DATA_W   = 16,
  parameter logic [31:0] M_MAX    = 32'h7FFF_FFFF,
  parameter int unsigned TH_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [31:0]               class_i,
  input  logic [31:0]               node_i,
  input  logic [VEC_LEN*DATA_W-1:0] X_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [31:0]               mem_class_o,
  output logic [31:0]               mem_node_o,
  output logic                      mem_rd_wr_o,
  output logic                      mem_X_c_o,
  output logic                      mem_C_c_o,
  output logic                      mem_W_c_o,
  output logic                      mem_T_c_o,
  output logic                      mem_M_c_o,
  output logic [VEC_LEN*DATA_W-1:0] mem_X_o,
  output logic [VEC_LEN*DATA_W-1:0] mem_W_o,
  output logic [31:0]               mem_Th_o,
  output logic [31:0]               mem_M_o,
  input  logic [VEC_LEN*DATA_W-1:0] mem_W_i,
  input  logic [31:0]               mem_Th_i,
  input  logic [31:0]               mem_M_i
);

  localparam int unsigned VecW = VEC_LEN * DATA_W;
  localparam int unsigned IdxW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic        Read  = 1'b0;
  localparam logic        Write = 1'b1;

  typedef enum logic [2:0] {StIdle, StRd, StCalc, StWr, StDone} state_e;

  state_e                state_q;
  logic                  busy_q, done_q, rd_wr_q;
  logic                  x_c_q, c_c_q, w_c_q, m_c_q;
  logic [31:0]           class_q, node_q, m_q;
  logic [VecW-1:0]       x_q, w_q;
  logic [IdxW-1:0]       idx_q;

  logic [31:0]           m_new;
  logic [4:0]            shift;
  logic [31:0]           off;
  logic signed [DATA_W-1:0] w_el, x_el, w_el_new;
  logic signed [DATA_W:0]   diff, step, sum;

  // Hit counter increment; negative counts restart at 0, and the count saturates.
  always_comb begin
    if (mem_M_i[31]) begin
      m_new = 32'd1;
    end else if (mem_M_i >= M_MAX) begin
      m_new = M_MAX;
    end else begin
      m_new = mem_M_i + 32'd1;
    end
  end

  // Priority encode floor(log2(M_new)); M_new is never 0 once captured.
  always_comb begin
    shift = '0;
    for (int i = 0; i < 32; i++) begin
      if (m_q[i]) shift = 5'(i);
    end
  end

  assign off = 32'(idx_q) * DATA_W;

  // Running-mean step for the current element; the result always lies between W and X.
  always_comb begin
    w_el     = w_q[off +: DATA_W];
    x_el     = x_q[off +: DATA_W];
    diff     = {x_el[DATA_W-1], x_el} - {w_el[DATA_W-1], w_el};
    step     = diff >>> shift;
    sum      = {w_el[DATA_W-1], w_el} + step;
    w_el_new = sum[DATA_W-1:0];
  end

`ifdef GAM_TH_DECAY_EN
  logic              t_c_q;
  logic [31:0]       th_q;
  logic signed [31:0] th_in, th_dec;

  // Threshold decay Th - (Th >>> TH_SHIFT), never below 0.
  always_comb begin
    th_in  = signed'(mem_Th_i);
    th_dec = th_in - (th_in >>> TH_SHIFT);
    if (th_dec < 0) th_dec = '0;
  end

  assign mem_T_c_o = t_c_q;
  assign mem_Th_o  = th_q;
`else
  logic unused_th;
  assign unused_th = ^mem_Th_i ^ (TH_SHIFT == 0);
  assign mem_T_c_o = 1'b0;
  assign mem_Th_o  = '0;
`endif

  // Command FSM with registered memory-port controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_wr_q <= Read;
      x_c_q   <= 1'b0;
      c_c_q   <= 1'b0;
      w_c_q   <= 1'b0;
      m_c_q   <= 1'b0;
      class_q <= '0;
      node_q  <= '0;
      m_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      idx_q   <= '0;
`ifdef GAM_TH_DECAY_EN
      t_c_q   <= 1'b0;
      th_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            class_q <= class_i;
            node_q  <= node_i;
            x_q     <= X_i;
            busy_q  <= 1'b1;
            rd_wr_q <= Read;
            w_c_q   <= 1'b1;
            m_c_q   <= 1'b1;
`ifdef GAM_TH_DECAY_EN
            t_c_q   <= 1'b1;
`endif
            state_q <= StRd;
          end
        end
        StRd: begin
          w_q     <= mem_W_i;
          m_q     <= m_new;
          idx_q   <= '0;
          w_c_q   <= 1'b0;
          m_c_q   <= 1'b0;
`ifdef GAM_TH_DECAY_EN
          th_q    <= th_dec;
          t_c_q   <= 1'b0;
`endif
          state_q <= StCalc;
        end
        StCalc: begin
          w_q[off +: DATA_W] <= w_el_new;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IdxW'(VEC_LEN - 1)) begin
            rd_wr_q <= Write;
            x_c_q   <= 1'b1;
            c_c_q   <= 1'b1;
            w_c_q   <= 1'b1;
            m_c_q   <= 1'b1;
`ifdef GAM_TH_DECAY_EN
            t_c_q   <= 1'b1;
`endif
            state_q <= StWr;
          end
        end
        StWr: begin
          rd_wr_q <= Read;
          x_c_q   <= 1'b0;
          c_c_q   <= 1'b0;
          w_c_q   <= 1'b0;
          m_c_q   <= 1'b0;
`ifdef GAM_TH_DECAY_EN
          t_c_q   <= 1'b0;
`endif
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_class_o = class_q;
  assign mem_node_o  = node_q;
  assign mem_rd_wr_o = rd_wr_q;
  assign mem_X_c_o   = x_c_q;
  assign mem_C_c_o   = c_c_q;
  assign mem_W_c_o   = w_c_q;
  assign mem_M_c_o   = m_c_q;
  assign mem_X_o     = x_q;
  assign mem_W_o     = w_q;
  assign mem_M_o     = m_q;

endmodule

// File: tb/tb_gam_node_updater.sv
// Scoreboard bench for gam_node_updater: stimulus pushes expected write-backs,
// a negedge monitor checks RD/WR port activity and done timing against them.
module tb_gam_node_updater;

  localparam int unsigned VW = 64;
  localparam logic [31:0] M_MAX = 32'h7FFF_FFFF;
`ifdef GAM_TH_DECAY_EN
  localparam bit TH_ON = 1'b1;
`else
  localparam bit TH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   class_i = '0, node_i = '0;
  logic [VW-1:0] X_i = '0;
  logic          busy_o, done_o;
  logic [31:0]   mem_class_o, mem_node_o;
  logic          mem_rd_wr_o;
  logic          mem_X_c_o, mem_C_c_o, mem_W_c_o, mem_T_c_o, mem_M_c_o;
  logic [VW-1:0] mem_X_o, mem_W_o;
  logic [31:0]   mem_Th_o, mem_M_o;
  logic [VW-1:0] mem_W_i = '0;
  logic [31:0]   mem_Th_i = '0, mem_M_i = '0;

  gam_node_updater dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .class_i     (class_i),
    .node_i      (node_i),
    .X_i         (X_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_class_o (mem_class_o),
    .mem_node_o  (mem_node_o),
    .mem_rd_wr_o (mem_rd_wr_o),
    .mem_X_c_o   (mem_X_c_o),
    .mem_C_c_o   (mem_C_c_o),
    .mem_W_c_o   (mem_W_c_o),
    .mem_T_c_o   (mem_T_c_o),
    .mem_M_c_o   (mem_M_c_o),
    .mem_X_o     (mem_X_o),
    .mem_W_o     (mem_W_o),
    .mem_Th_o    (mem_Th_o),
    .mem_M_o     (mem_M_o),
    .mem_W_i     (mem_W_i),
    .mem_Th_i    (mem_Th_i),
    .mem_M_i     (mem_M_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   cls;
    logic [31:0]   node;
    logic [VW-1:0] x;
    logic [VW-1:0] w;
    logic [31:0]   m;
    logic [31:0]   th;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element 0 sits in the least significant DATA_W bits.
  function automatic logic [VW-1:0] vec(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic send(input logic [31:0] cls, input logic [31:0] node, input logic [VW-1:0] x,
                      input logic [VW-1:0] w_in, input logic [31:0] m_in,
                      input logic [31:0] th_in, input logic [VW-1:0] w_exp,
                      input logic [31:0] m_exp, input logic [31:0] th_exp);
    exp_t e;
    @(posedge clk);
    #1;
    mem_W_i  = w_in;
    mem_M_i  = m_in;
    mem_Th_i = th_in;
    class_i  = cls;
    node_i   = node;
    X_i      = x;
    e.cls    = cls;
    e.node   = node;
    e.x      = x;
    e.w      = w_exp;
    e.m      = m_exp;
    e.th     = TH_ON ? th_exp : 32'd0;
    e.acc    = cyc;
    exp_q.push_back(e);
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    // Scramble command inputs; the DUT must have latched them.
    class_i  = 32'hDEAD_BEEF;
    node_i   = 32'hCAFE_F00D;
    X_i      = {VW{1'b1}};
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
    end
    if (!got) chk("done_timeout", 64'(done_o), 64'd1);
  endtask

  // Monitor: checks RD and WR port cycles and done timing against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_wr_o == 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(mem_rd_wr_o), 64'd0);
        end else begin
          wr_seen++;
          chk("wr_cycle", 64'(cyc - exp_q[0].acc), 64'd6);
          chk("wr_enables", 64'({mem_X_c_o, mem_C_c_o, mem_W_c_o, mem_T_c_o, mem_M_c_o}),
              64'({4'b1110, 1'b0} | {3'b000, TH_ON, 1'b1}));
          chk("wr_class", 64'(mem_class_o), 64'(exp_q[0].cls));
          chk("wr_node", 64'(mem_node_o), 64'(exp_q[0].node));
          chk("wr_x", mem_X_o, exp_q[0].x);
          chk("wr_w", mem_W_o, exp_q[0].w);
          chk("wr_m", 64'(mem_M_o), 64'(exp_q[0].m));
          chk("wr_th", 64'(mem_Th_o), 64'(exp_q[0].th));
          chk("wr_busy", 64'(busy_o), 64'd1);
        end
      end else if (mem_W_c_o || mem_M_c_o || mem_X_c_o || mem_C_c_o || mem_T_c_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 64'(mem_W_c_o), 64'd0);
        end else begin
          chk("rd_cycle", 64'(cyc - exp_q[0].acc), 64'd1);
          chk("rd_enables", 64'({mem_X_c_o, mem_C_c_o, mem_W_c_o, mem_T_c_o, mem_M_c_o}),
              64'({3'b001, TH_ON, 1'b1}));
          chk("rd_idx", 64'({mem_class_o, mem_node_o}), 64'({exp_q[0].cls, exp_q[0].node}));
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done_o), 64'd0);
        end else begin
          chk("done_cycle", 64'(cyc - exp_q[0].acc), 64'd7);
          chk("done_busy", 64'(busy_o), 64'd0);
          chk("single_write", 64'(wr_seen), 64'd1);
          wr_seen = 0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset_ctrl", 64'({busy_o, done_o, mem_rd_wr_o, mem_X_c_o, mem_C_c_o, mem_W_c_o,
                           mem_T_c_o, mem_M_c_o}), 64'd0);
    chk("reset_idx", {mem_class_o, mem_node_o}, 64'd0);
    chk("reset_x", mem_X_o, 64'd0);
    chk("reset_w", mem_W_o, 64'd0);
    chk("reset_m_th", {mem_M_o, mem_Th_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fresh node: s = 0, W takes X.
    send(32'd1, 32'd2, vec(100, -100, 7, 0), vec(0, 0, 0, 0), 32'd0, 32'd80,
         vec(100, -100, 7, 0), 32'd1, 32'd70);
    wait_done();

    // M = 3 -> M_new = 4, s = 2.
    send(32'd3, 32'd4, vec(100, -100, 7, -7), vec(0, 0, 0, 0), 32'd3, 32'd0,
         vec(25, -25, 1, -2), 32'd4, 32'd0);
    wait_done();

    // Saturated counter stays at M_MAX, W unchanged.
    send(32'd6, 32'd7, vec(5, 5, 5, 5), vec(5, 5, 5, 5), M_MAX, 32'd8,
         vec(5, 5, 5, 5), M_MAX, 32'd7);
    wait_done();

    // M_MAX-1 -> M_new = M_MAX, s = 30: positive steps vanish, negative floor to -1.
    send(32'd8, 32'd9, vec(3, -3, 0, 0), vec(0, 0, 0, 0), M_MAX - 32'd1, 32'd16,
         vec(0, -1, 0, 0), M_MAX, 32'd14);
    wait_done();

    // Start during CALC with other indices is ignored; s = 1.
    send(32'd5, 32'd9, vec(20, 0, -10, -5), vec(10, 20, -30, 0), 32'd1, 32'd40,
         vec(15, 10, -20, -3), 32'd2, 32'd35);
    @(posedge clk);
    @(posedge clk);
    #1;
    class_i = 32'd77;
    node_i  = 32'd88;
    X_i     = vec(1, 1, 1, 1);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done();

    // Back-to-back after done; negative M counts as 0.
    send(32'd10, 32'd11, vec(-1, -2, -3, -4), vec(1, 2, 3, 4), 32'hFFFF_FFFB, 32'd0,
         vec(-1, -2, -3, -4), 32'd1, 32'd0);
    wait_done();

    // Reset during CALC cycle 3 aborts without a write.
    send(32'd12, 32'd13, vec(9, 9, 9, 9), vec(0, 0, 0, 0), 32'd0, 32'd0,
         vec(9, 9, 9, 9), 32'd1, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 64'({busy_o, done_o, mem_rd_wr_o, mem_X_c_o, mem_C_c_o, mem_W_c_o,
                           mem_T_c_o, mem_M_c_o}), 64'd0);
    exp_q.delete();
    wr_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Normal command after abort; extreme element spans the full range, s = 2.
    send(32'd14, 32'd15, vec(8, 0, 0, 32767), vec(0, 100, -100, -32768), 32'd6, 32'd80,
         vec(2, 75, -75, -16385), 32'd7, 32'd70);
    wait_done();

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gam_node_updater.md
Name: gam_node_updater

Overview:
- Initiator on the GAM memory-layer port; drives class/node indices, RD_WR_T direction and per-field enables (X_c, C_c, W_c, T_c, M_c).
- On each command it does a read-modify-write of one node:
  - reads W and M;
  - computes a running-mean weight update, one vector element per cycle;
  - writes back X, class name, W and M.
- Sits between the learning controller and the memory layer; the memory-layer read path is combinational.

Parameters:
- VEC_LEN, 4, elements per node vector (node_vector_T length).
- DATA_W, 16, signed width of one vector element.
- M_MAX, 32'h7FFF_FFFF, saturation value of the node hit counter M.
- TH_SHIFT, 3, decay shift for threshold (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  command strobe, sampled in IDLE only
- class_i  in  32  target class index (int)
- node_i  in  32  target node index (int)
- X_i  in  VEC_LEN*DATA_W  input sample (node_vector_T)
- busy_o  out  1  high from the cycle after accepted start until done
- done_o  out  1  one-cycle pulse, update committed
- mem_class_o  out  32  class index to memory
- mem_node_o  out  32  node index to memory
- mem_rd_wr_o  out  RD_WR_T  READ/WRITE
- mem_X_c_o, mem_C_c_o, mem_W_c_o, mem_T_c_o, mem_M_c_o  out  1 each  field enables
- mem_X_o, mem_W_o  out  VEC_LEN*DATA_W  write data
- mem_Th_o, mem_M_o  out  32  write data
- mem_W_i  in  VEC_LEN*DATA_W  read data
- mem_Th_i, mem_M_i  in  32  read data

Behaviour:
- Clock, reset and clocking:
  - One clock: clk.
  - Reset is asynchronous and active-low (rst_n); all flops reset.
- Reset values:
  - state = IDLE; busy_o = 0, done_o = 0.
  - mem_rd_wr_o = READ; all enables = 0.
  - Index and data registers = 0.
- FSM: IDLE -> RD -> CALC -> WR -> DONE -> IDLE.
- IDLE:
  - start_i = 1 latches class_i, node_i and X_i; go to RD.
  - start_i outside IDLE is ignored (no queueing).
- RD (1 cycle):
  - mem_rd_wr_o = READ, mem_W_c_o = 1, mem_M_c_o = 1.
  - Capture mem_W_i and mem_M_i at the clock edge.
  - M_new = M + 1, saturating at M_MAX; negative M is treated as 0.
- Shift for the update:
  - s = floor(log2(M_new)), priority encode.
  - M = 0 gives s = 0, so W_new = X.
- CALC (VEC_LEN cycles):
  - Element counter idx runs 0..VEC_LEN-1; one element per cycle.
  - d = X[idx] - W[idx] in DATA_W+1 signed bits.
  - W[idx] <= W[idx] + (d >>> s), truncated to DATA_W.
  - No overflow is possible: the result lies between W and X.
  - Leave CALC when idx = VEC_LEN-1.
- WR (1 cycle):
  - mem_rd_wr_o = WRITE; X_c = C_c = W_c = M_c = 1; T_c = 0 unless the optional feature is on.
  - mem_X_o = latched X, mem_W_o = updated W, mem_M_o = M_new.
  - The class name is written as class_i by the memory itself.
- DONE (1 cycle): done_o = 1; busy_o = 0 in the same cycle.
- Outside RD and WR:
  - mem_rd_wr_o = READ; all enables = 0.
  - mem_class_o and mem_node_o hold the latched indices.
- Latency:
  - start accepted at cycle 0: RD at cycle 1, CALC at cycles 2..VEC_LEN+1, WR at cycle VEC_LEN+2, done_o at cycle VEC_LEN+3.
  - For the default VEC_LEN = 4, done_o is at cycle 7.
  - Back-to-back: a new start is accepted the cycle after done_o.
- Reset mid-operation:
  - Immediate abort; the memory is not written.
  - Enables drop asynchronously.

Optional Feature:
- Macro GAM_TH_DECAY_EN.
- Defined:
  - RD also asserts mem_T_c_o and captures mem_Th_i.
  - WR asserts mem_T_c_o with mem_Th_o = Th - (Th >>> TH_SHIFT), floored at 0.
- Undefined: mem_T_c_o is tied to 0 and mem_Th_o to 0; no Th register exists.

Test Plan:
- Fresh node: M=0, W={0,0,0,0}, X={100,-100,7,0} -> WR at cycle 6 with W={100,-100,7,0}, M=1; done_o at cycle 7 only.
- Existing node, M=3 (s=2): W={0,0,0,0}, X={100,-100,7,-7} -> W={25,-25,1,-2}, M=4.
- Saturation: M=M_MAX, W=X={5,5,5,5} -> M written as M_MAX, W unchanged.
- start_i pulsed again during CALC with different class/node -> ignored; exactly one WR to the first indices; next start is accepted after done_o.
- rst_n low during CALC cycle 3 -> all enables 0 immediately; no WRITE seen; busy_o=0; a subsequent start completes normally.
- GAM_TH_DECAY_EN defined, Th=80 -> T_c high in RD and WR, mem_Th_o=70; Th=0 -> mem_Th_o=0.
